// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
//   Shared definitions for the single-issue ALU control path: sequencer state
//   encoding, the supported major opcodes, the PC increment and an opcode
//   legality helper.
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALTED    = 3'd5
   } state_e;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE = 7'b0010011;
   localparam int         PC_STEP   = 4;

   // Only register-register and register-immediate ALU ops reach the engine.
   function automatic logic is_legal_opc(input logic [6:0] opc);
      return (opc == OPC_RTYPE) || (opc == OPC_ITYPE);
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
//   Cycle counter bounding how long the sequencer waits for the ALU.
//   Ports:
//     clk, rst_n  : clock / async active-low reset
//     i_clr       : zero the counter (asserted the cycle before EXECUTE entry)
//     i_en        : count this cycle (high while in EXECUTE)
//     o_expired   : high in the TIMEOUT-th enabled cycle after a clear
// -----------------------------------------------------------------------------
module seq_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   // The counter holds (cycles spent in EXECUTE - 1), so the last allowed
   // cycle is the one where it reads TIMEOUT-1.
   assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_cnt <= '0;
      else if (i_clr)    r_cnt <= '0;
      else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//   Multi-cycle control FSM for the single-issue RISC-V ALU datapath:
//   IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> (FETCH | HALTED).
//   Ports:
//     clk, rst               : clock / async active-low reset
//     imem_req/addr/valid/instr : instruction fetch handshake
//     instr_q                : latched instruction driving the datapath fields
//     alu_start/alu_done     : ALU engine handshake
//     rf_we/rf_rd            : register-file write-back strobe and target
//     halt/halted            : halt request (sampled in WRITEBACK) and status
//     illegal/alu_timeout    : sticky error flags
//     pc/retire_cnt          : program counter and retired-instruction count
// -----------------------------------------------------------------------------
module exec_sequencer
   import riscv_ctrl_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] PC_RESET    = '0,
   parameter int               IMEM_WORDS  = 256,
   parameter int               ALU_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_valid,
   input  logic [31:0]      imem_instr,
   output logic [31:0]      instr_q,
   output logic             alu_start,
   input  logic             alu_done,
   output logic             rf_we,
   output logic [4:0]       rf_rd,
   input  logic             halt,
   output logic             halted,
   output logic             illegal,
   output logic             alu_timeout,
   output logic [WIDTH-1:0] pc,
   output logic [31:0]      retire_cnt
);

   localparam logic [WIDTH-1:0] PC_MASK = WIDTH'(IMEM_WORDS * 4 - 1);

   state_e           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [31:0]      r_instr_q;
   logic [31:0]      r_retire_cnt;
   logic             r_imem_req;
   logic             r_alu_start;
   logic             r_rf_we;
   logic             r_halted;
   logic             r_illegal;
   logic             r_alu_timeout;

   logic             w_wd_expired;
   logic [WIDTH-1:0] w_pc_next;

   assign w_pc_next = (r_pc + WIDTH'(PC_STEP)) & PC_MASK;

   seq_watchdog #(.TIMEOUT(ALU_TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst_n     (rst),
      .i_clr     (r_state == ST_DECODE),
      .i_en      (r_state == ST_EXECUTE),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_pc          <= PC_RESET;
         r_instr_q     <= '0;
         r_retire_cnt  <= '0;
         r_imem_req    <= 1'b0;
         r_alu_start   <= 1'b0;
         r_rf_we       <= 1'b0;
         r_halted      <= 1'b0;
         r_illegal     <= 1'b0;
         r_alu_timeout <= 1'b0;
      end else begin
         // Single-cycle strobes default low every cycle.
         r_alu_start <= 1'b0;
         r_rf_we     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_state    <= ST_FETCH;
               r_imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_valid) begin
                  r_instr_q  <= imem_instr;
                  r_imem_req <= 1'b0;
                  r_state    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (is_legal_opc(r_instr_q[6:0])) begin
                  r_state     <= ST_EXECUTE;
                  r_alu_start <= 1'b1;
               end else begin
                  // Retire the instruction without touching the ALU or RF.
                  r_illegal <= 1'b1;
                  r_state   <= ST_WRITEBACK;
               end
            end
            ST_EXECUTE: begin
               // r_alu_start is high only in the entry cycle, where a done
               // left over from a previous op must not be taken.
               if (!r_alu_start && alu_done) begin
                  r_state <= ST_WRITEBACK;
                  r_rf_we <= (r_instr_q[11:7] != 5'd0);
               end else if (w_wd_expired) begin
                  r_alu_timeout <= 1'b1;
                  r_state       <= ST_WRITEBACK;
               end
            end
            ST_WRITEBACK: begin
               r_pc         <= w_pc_next;
               r_retire_cnt <= r_retire_cnt + 32'd1;
               if (halt) begin
                  r_state  <= ST_HALTED;
                  r_halted <= 1'b1;
               end else begin
                  r_state    <= ST_FETCH;
                  r_imem_req <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (!halt) begin
                  r_state    <= ST_FETCH;
                  r_halted   <= 1'b0;
                  r_imem_req <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_imem_req <= 1'b0;
               r_halted   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_pc;
   assign instr_q     = r_instr_q;
   assign alu_start   = r_alu_start;
   assign rf_we       = r_rf_we;
   assign rf_rd       = r_instr_q[11:7];
   assign halted      = r_halted;
   assign illegal     = r_illegal;
   assign alu_timeout = r_alu_timeout;
   assign pc          = r_pc;
   assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_instr = '0;
   logic        alu_done = 1'b0;
   logic        halt = 1'b0;
   logic        imem_req, alu_start, rf_we, halted, illegal, alu_timeout;
   logic [31:0] imem_addr, instr_q, pc, retire_cnt;
   logic [4:0]  rf_rd;

   int checks = 0;
   int failures = 0;

   exec_sequencer dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_instr(imem_instr), .instr_q(instr_q),
      .alu_start(alu_start), .alu_done(alu_done),
      .rf_we(rf_we), .rf_rd(rf_rd),
      .halt(halt), .halted(halted), .illegal(illegal), .alu_timeout(alu_timeout),
      .pc(pc), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // From a FETCH cycle: legal instruction, done one cycle after start.
   task automatic run_instr(input logic [31:0] ins);
      imem_valid = 1'b1; imem_instr = ins;
      tick(); imem_valid = 1'b0;
      tick();
      tick(); alu_done = 1'b1;
      tick(); alu_done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req: got %b exp 0", imem_req); end
      checks++; if (alu_start !== 1'b0) begin failures++; $display("FAIL rst_alu_start: got %b exp 0", alu_start); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_rf_we: got %b exp 0", rf_we); end
      checks++; if (pc !== 32'd0) begin failures++; $display("FAIL rst_pc: got %h exp 0", pc); end
      checks++; if (instr_q !== 32'd0) begin failures++; $display("FAIL rst_instr_q: got %h exp 0", instr_q); end
      checks++; if (retire_cnt !== 32'd0) begin failures++; $display("FAIL rst_retire: got %0d exp 0", retire_cnt); end
      checks++; if ({halted, illegal, alu_timeout} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b exp 000", {halted, illegal, alu_timeout}); end
      rst = 1'b1;
   endtask

   task automatic test_legal();
      // IDLE now; data is ready before FETCH is entered.
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b exp 0", imem_req); end
      imem_valid = 1'b1; imem_instr = 32'h002081B3;
      tick(); // c1 FETCH
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL fetch1: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      tick(); imem_valid = 1'b0; // c2 DECODE
      checks++; if (instr_q !== 32'h002081B3 || imem_req !== 1'b0) begin failures++; $display("FAIL decode1: got instr=%h req=%b exp 002081b3 0", instr_q, imem_req); end
      tick(); // c3 EXECUTE entry
      checks++; if (alu_start !== 1'b1) begin failures++; $display("FAIL start1: got %b exp 1", alu_start); end
      tick(); alu_done = 1'b1; // c4
      checks++; if (alu_start !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL exec2: got start=%b we=%b exp 0 0", alu_start, rf_we); end
      tick(); alu_done = 1'b0; // c5 WRITEBACK
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3) begin failures++; $display("FAIL wb1: got we=%b rd=%0d exp we=1 rd=3", rf_we, rf_rd); end
      tick(); // FETCH
      checks++; if (pc !== 32'd4 || retire_cnt !== 32'd1) begin failures++; $display("FAIL retire1: got pc=%0d cnt=%0d exp 4 1", pc, retire_cnt); end
      checks++; if (rf_we !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL refetch1: got we=%b req=%b exp 0 1", rf_we, imem_req); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin imem_valid = 1'b1; imem_instr = 32'h00A00093; end
         else imem_instr = 32'hDEADBEEF;
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4 || instr_q !== 32'h002081B3) begin
            failures++; $display("FAIL stall_%0d: got req=%b addr=%h instr=%h exp 1 4 002081b3", i, imem_req, imem_addr, instr_q); end
         tick();
      end
      imem_valid = 1'b0;
      checks++; if (instr_q !== 32'h00A00093 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_latch: got instr=%h req=%b exp 00a00093 0", instr_q, imem_req); end
      tick(); tick(); alu_done = 1'b1;
      tick(); alu_done = 1'b0;
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd1) begin failures++; $display("FAIL stall_wb: got we=%b rd=%0d exp 1 1", rf_we, rf_rd); end
      tick();
      checks++; if (pc !== 32'd8 || retire_cnt !== 32'd2) begin failures++; $display("FAIL stall_retire: got pc=%0d cnt=%0d exp 8 2", pc, retire_cnt); end
   endtask

   task automatic test_illegal_rd0();
      imem_valid = 1'b1; imem_instr = 32'h00000003;
      tick(); imem_valid = 1'b0; // DECODE
      tick(); // WRITEBACK directly
      checks++; if (illegal !== 1'b1 || alu_start !== 1'b0 || rf_we !== 1'b0) begin
         failures++; $display("FAIL illegal_wb: got ill=%b start=%b we=%b exp 1 0 0", illegal, alu_start, rf_we); end
      tick();
      checks++; if (pc !== 32'd12 || retire_cnt !== 32'd3 || illegal !== 1'b1) begin
         failures++; $display("FAIL illegal_retire: got pc=%0d cnt=%0d ill=%b exp 12 3 1", pc, retire_cnt, illegal); end
      // addi x0,x0,1
      imem_valid = 1'b1; imem_instr = 32'h00100013;
      tick(); imem_valid = 1'b0;
      tick();
      checks++; if (alu_start !== 1'b1) begin failures++; $display("FAIL rd0_start: got %b exp 1", alu_start); end
      tick(); alu_done = 1'b1;
      tick(); alu_done = 1'b0;
      checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd0) begin failures++; $display("FAIL rd0_we: got we=%b rd=%0d exp 0 0", rf_we, rf_rd); end
      tick();
      checks++; if (pc !== 32'd16 || retire_cnt !== 32'd4 || imem_req !== 1'b1) begin
         failures++; $display("FAIL rd0_retire: got pc=%0d cnt=%0d req=%b exp 16 4 1", pc, retire_cnt, imem_req); end
   endtask

   task automatic test_watchdog();
      imem_valid = 1'b1; imem_instr = 32'h002081B3;
      tick(); imem_valid = 1'b0;
      tick(); alu_done = 1'b1; // EXECUTE cycle 1: done here must be ignored
      tick(); alu_done = 1'b0; // EXECUTE cycle 2
      checks++; if (rf_we !== 1'b0 || alu_start !== 1'b0 || alu_timeout !== 1'b0) begin
         failures++; $display("FAIL wd_entry_done: got we=%b start=%b to=%b exp 0 0 0", rf_we, alu_start, alu_timeout); end
      for (int i = 0; i < 14; i++) tick(); // EXECUTE cycle 16
      checks++; if (alu_timeout !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL wd_cycle16: got to=%b we=%b exp 0 0", alu_timeout, rf_we); end
      tick(); // WRITEBACK
      checks++; if (alu_timeout !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL wd_fire: got to=%b we=%b exp 1 0", alu_timeout, rf_we); end
      tick();
      checks++; if (imem_req !== 1'b1 || pc !== 32'd20 || retire_cnt !== 32'd5) begin
         failures++; $display("FAIL wd_next: got req=%b pc=%0d cnt=%0d exp 1 20 5", imem_req, pc, retire_cnt); end
   endtask

   task automatic test_wrap_halt();
      for (int n = 0; n < 300 && pc !== 32'd1020; n++) run_instr(32'h002081B3);
      checks++; if (pc !== 32'd1020 || retire_cnt !== 32'd255) begin failures++; $display("FAIL pre_wrap: got pc=%0d cnt=%0d exp 1020 255", pc, retire_cnt); end
      halt = 1'b1; // raised during FETCH
      imem_valid = 1'b1; imem_instr = 32'h002081B3;
      tick(); imem_valid = 1'b0;
      tick();
      tick(); alu_done = 1'b1;
      tick(); alu_done = 1'b0;
      checks++; if (rf_we !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL halt_wb: got we=%b halted=%b exp 1 0", rf_we, halted); end
      tick();
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'd0 || retire_cnt !== 32'd256) begin
         failures++; $display("FAIL halted: got h=%b req=%b pc=%0d cnt=%0d exp 1 0 0 256", halted, imem_req, pc, retire_cnt); end
      tick(); tick();
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'd0) begin failures++; $display("FAIL halt_hold: got h=%b req=%b pc=%0d exp 1 0 0", halted, imem_req, pc); end
      halt = 1'b0;
      tick();
      checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
         failures++; $display("FAIL resume: got h=%b req=%b addr=%h exp 0 1 0", halted, imem_req, imem_addr); end
      run_instr(32'h002081B3);
      checks++; if (pc !== 32'd4 || retire_cnt !== 32'd257) begin failures++; $display("FAIL post_resume: got pc=%0d cnt=%0d exp 4 257", pc, retire_cnt); end
   endtask

   task automatic test_async_reset();
      imem_valid = 1'b1; imem_instr = 32'h002081B3;
      tick(); imem_valid = 1'b0;
      tick();
      tick(); alu_done = 1'b1; // next edge would enter WRITEBACK
      #2 rst = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b0 || alu_start !== 1'b0 || imem_req !== 1'b0) begin
         failures++; $display("FAIL arst_strobes: got we=%b start=%b req=%b exp 0 0 0", rf_we, alu_start, imem_req); end
      checks++; if (pc !== 32'd0 || retire_cnt !== 32'd0 || instr_q !== 32'd0) begin
         failures++; $display("FAIL arst_state: got pc=%0d cnt=%0d instr=%h exp 0 0 0", pc, retire_cnt, instr_q); end
      checks++; if ({illegal, alu_timeout, halted} !== 3'b000) begin failures++; $display("FAIL arst_flags: got %b exp 000", {illegal, alu_timeout, halted}); end
      tick();
      checks++; if (rf_we !== 1'b0 || retire_cnt !== 32'd0) begin failures++; $display("FAIL arst_hold: got we=%b cnt=%0d exp 0 0", rf_we, retire_cnt); end
      alu_done = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL arst_refetch: got req=%b addr=%h exp 1 0", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_legal();
      test_stall();
      test_illegal_rd0();
      test_watchdog();
      test_wrap_halt();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
